// File: rtl/spi_master_p.sv
// spi_master_p: single-word full-duplex SPI master with runtime CPOL/CPHA and NCS active-low chip selects
// Optional feature: define SPI_LSB_FIRST_EN to add i_lsb_first (LSB-first shifting); default is MSB-first.
// Ports: i_clk, i_rst (async, active-high); i_start/o_busy/o_done host handshake;
//   i_dout/o_din transmit and received words; i_cpol/i_cpha/i_cs_sel per-transfer setup latched on start;
//   o_cs/o_sck/o_mosi/i_miso SPI pins, all outputs registered.
module spi_master_p #(
  parameter int WIDTH = 8,
  parameter int NCS = 1,
  parameter int DIV = 2,
  localparam int SW = NCS > 1 ? $clog2(NCS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dout,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [SW-1:0]    i_cs_sel,
`ifdef SPI_LSB_FIRST_EN
  input  logic             i_lsb_first,
`endif
  output logic [WIDTH-1:0] o_din,
  output logic             o_busy,
  output logic             o_done,
  output logic [NCS-1:0]   o_cs,
  output logic             o_sck,
  input  logic             i_miso,
  output logic             o_mosi
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int HW = $clog2(2 * WIDTH);
  typedef enum logic [1:0] {IDLE, LEAD, XFER, LAG} state_t;
  state_t r_st, w_st;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [HW-1:0] r_half, w_half;
  logic [WIDTH-1:0] r_tx, w_tx, r_rx, w_rx, r_din, w_din;
  logic [NCS-1:0] r_cs, w_cs;
  logic r_sck, w_sck, r_mosi, w_mosi, r_busy, w_busy, r_done, w_done;
  logic r_cpha, w_cpha, r_lsb, w_lsb;
  logic w_lsb_in, w_tick, w_lead, w_last, w_edge, w_sample, w_shift;
`ifdef SPI_LSB_FIRST_EN
  assign w_lsb_in = i_lsb_first;
`else
  assign w_lsb_in = 1'b0;
`endif
  assign w_tick = r_cnt == CW'(DIV - 1);
  // an SCK toggle into an even half-period (or out of LEAD) is a leading edge
  assign w_lead = r_st == LEAD || r_half[0];
  assign w_last = r_half == HW'(2 * WIDTH - 1);
  assign w_edge = w_tick && (r_st == LEAD || (r_st == XFER && !w_last));
  assign w_sample = w_edge && (w_lead ^ r_cpha);
  // CPHA=0 already presented bit 0 in LEAD, so its final trailing edge must not shift
  assign w_shift = w_edge && !(w_lead ^ r_cpha) && !(r_st == XFER && r_half == HW'(2 * WIDTH - 2));
  always_comb begin
    w_st = r_st;
    w_cnt = w_tick ? '0 : r_cnt + 1'b1;
    w_half = r_half;
    w_sck = w_edge ? ~r_sck : r_sck;
    w_mosi = w_shift ? (r_lsb ? r_tx[0] : r_tx[WIDTH-1]) : r_mosi;
    w_tx = w_shift ? (r_lsb ? r_tx >> 1 : r_tx << 1) : r_tx;
    w_rx = w_sample ? (r_lsb ? {i_miso, r_rx[WIDTH-1:1]} : {r_rx[WIDTH-2:0], i_miso}) : r_rx;
    w_din = r_din;
    w_cs = r_cs;
    w_busy = r_busy;
    w_done = 1'b0;
    w_cpha = r_cpha;
    w_lsb = r_lsb;
    case (r_st)
      IDLE: begin
        w_cnt = '0;
        w_sck = i_cpol;
        w_cs = '1;
        w_mosi = 1'b0;
        w_busy = 1'b0;
        if (i_start) begin
          w_st = LEAD;
          w_busy = 1'b1;
          w_cs = ~(NCS'(1) << i_cs_sel);
          w_cpha = i_cpha;
          w_lsb = w_lsb_in;
          w_rx = '0;
          w_mosi = i_cpha ? 1'b0 : (w_lsb_in ? i_dout[0] : i_dout[WIDTH-1]);
          w_tx = i_cpha ? i_dout : (w_lsb_in ? i_dout >> 1 : i_dout << 1);
        end
      end
      LEAD: if (w_tick) begin
        w_st = XFER;
        w_half = '0;
      end
      XFER: if (w_tick) begin
        w_st = w_last ? LAG : XFER;
        w_half = r_half + 1'b1;
      end
      default: if (w_tick) begin
        w_st = IDLE;
        w_cs = '1;
        w_mosi = 1'b0;
        w_din = r_rx;
        w_done = 1'b1;
        w_busy = 1'b0;
      end
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_st <= IDLE;
      r_cnt <= '0;
      r_half <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_din <= '0;
      r_cs <= '1;
      r_sck <= 1'b0;
      r_mosi <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cpha <= 1'b0;
      r_lsb <= 1'b0;
    end else begin
      r_st <= w_st;
      r_cnt <= w_cnt;
      r_half <= w_half;
      r_tx <= w_tx;
      r_rx <= w_rx;
      r_din <= w_din;
      r_cs <= w_cs;
      r_sck <= w_sck;
      r_mosi <= w_mosi;
      r_busy <= w_busy;
      r_done <= w_done;
      r_cpha <= w_cpha;
      r_lsb <= w_lsb;
    end
  end
  assign o_din = r_din;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_cs = r_cs;
  assign o_sck = r_sck;
  assign o_mosi = r_mosi;
endmodule
